// File: rtl/elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : elastic_pipe
// Description : Valid/ready pipeline of STAGES register slices with flush,
//               occupancy count and an optional per-slice skid slot.
// Revision    : 1.0 - initial release
// ============================================================================
module elastic_pipe #(
    parameter int DATA_W = 32,
    parameter int STAGES = 1,
    parameter int SKID   = 0
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   flush_i,
    input  logic                                   in_valid_i,
    input  logic [DATA_W-1:0]                      in_data_i,
    output logic                                   in_ready_o,
    output logic                                   out_valid_o,
    output logic [DATA_W-1:0]                      out_data_o,
    input  logic                                   out_ready_i,
    output logic [$clog2(STAGES*(1+SKID)+1)-1:0]   count_o
);

    localparam int c_ST = (STAGES < 1) ? 1 : STAGES;
    localparam int c_CW = $clog2(STAGES*(1+SKID)+1);

    if (STAGES < 1) begin : g_bad_stages
        $error("elastic_pipe: STAGES must be >= 1");
    end

    logic [c_ST-1:0]   r_v;
    logic [DATA_W-1:0] r_d [c_ST];
    logic [c_ST:0]     w_rdy;
    logic [c_ST-1:0]   w_up_v;
    logic [DATA_W-1:0] w_up_d [c_ST];
    logic              w_accept;
    logic              w_emit;
    logic [c_CW-1:0]   r_count;

    // Slice k is fed by slice k-1; slice 0 is fed by the upstream port.
    always_comb begin
        w_up_v[0] = in_valid_i;
        w_up_d[0] = in_data_i;
        for (int k = 1; k < c_ST; k++) begin
            w_up_v[k] = r_v[k-1];
            w_up_d[k] = r_d[k-1];
        end
    end

    if (SKID == 0) begin : g_direct
        always_comb begin : p_ready_chain
            logic w_chain;
            w_chain     = out_ready_i;
            w_rdy[c_ST] = w_chain;
            for (int k = c_ST - 1; k >= 0; k--) begin
                w_chain  = !r_v[k] || w_chain;
                w_rdy[k] = w_chain;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v <= '0;
                for (int k = 0; k < c_ST; k++) r_d[k] <= '0;
            end else begin
                for (int k = 0; k < c_ST; k++) begin
                    r_v[k] <= flush_i ? 1'b0 : (w_rdy[k] ? w_up_v[k] : r_v[k]);
                    // Data only moves with a valid payload so idle garbage never lands.
                    if (w_rdy[k] && w_up_v[k]) r_d[k] <= w_up_d[k];
                end
            end
        end
    end else begin : g_skid
        logic [c_ST-1:0]   r_sv;
        logic [DATA_W-1:0] r_sd [c_ST];
        logic [c_ST-1:0]   w_push;
        logic [c_ST-1:0]   w_pop;

        always_comb begin
            w_rdy[c_ST] = out_ready_i;
            for (int k = 0; k < c_ST; k++) begin
                w_rdy[k]  = !r_sv[k];
                w_push[k] = w_up_v[k] && !r_sv[k];
                w_pop[k]  = r_v[k] && w_rdy[k+1];
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_v  <= '0;
                r_sv <= '0;
                for (int k = 0; k < c_ST; k++) begin
                    r_d[k]  <= '0;
                    r_sd[k] <= '0;
                end
            end else begin
                for (int k = 0; k < c_ST; k++) begin
                    if (flush_i) begin
                        r_v[k]  <= 1'b0;
                        r_sv[k] <= 1'b0;
                    end else if (r_sv[k]) begin
                        // Skid holds the younger entry: it refills main first.
                        if (w_pop[k]) begin
                            r_d[k]  <= r_sd[k];
                            r_sv[k] <= 1'b0;
                        end
                    end else if (w_push[k]) begin
                        if (!r_v[k] || w_pop[k]) begin
                            r_v[k] <= 1'b1;
                            r_d[k] <= w_up_d[k];
                        end else begin
                            r_sv[k] <= 1'b1;
                            r_sd[k] <= w_up_d[k];
                        end
                    end else if (w_pop[k]) begin
                        r_v[k] <= 1'b0;
                    end
                end
            end
        end
    end

    assign w_accept = in_valid_i && w_rdy[0];
    assign w_emit   = r_v[c_ST-1] && out_ready_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (flush_i) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_CW'(w_accept) - c_CW'(w_emit);
        end
    end

    assign in_ready_o  = w_rdy[0];
    assign out_valid_o = r_v[c_ST-1];
    assign out_data_o  = r_d[c_ST-1];
    assign count_o     = r_count;

endmodule
`default_nettype wire

// File: tb/tb_elastic_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_elastic_pipe
// Description : Self-checking bench for elastic_pipe across six STAGES/SKID
//               configurations sharing one stimulus stream, each checked
//               against a queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_elastic_pipe;

    localparam int          NI   = 6;
    // Per-instance configs, index 0..5: (3,0) (2,1) (1,0) (4,1) (1,1) (4,0)
    localparam logic [23:0] ST_P = 24'h414123;
    localparam logic [5:0]  SK_P = 6'b011010;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        in_valid_i;
    logic        out_ready_i;
    logic [31:0] in_data_i;

    logic        in_rdy  [NI];
    logic        out_v   [NI];
    logic [31:0] out_d   [NI];
    logic [3:0]  cnt_all [NI];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int S   = int'(ST_P[g*4 +: 4]);
        localparam int K   = int'(SK_P[g]);
        localparam int CAP = S * (1 + K);
        localparam int CW  = $clog2(CAP + 1);

        logic [CW-1:0] cnt;

        elastic_pipe #(.DATA_W(32), .STAGES(S), .SKID(K)) u_dut (
            .clk         (clk),
            .rst         (rst),
            .flush_i     (flush_i),
            .in_valid_i  (in_valid_i),
            .in_data_i   (in_data_i),
            .in_ready_o  (in_rdy[g]),
            .out_valid_o (out_v[g]),
            .out_data_o  (out_d[g]),
            .out_ready_i (out_ready_i),
            .count_o     (cnt)
        );

        assign cnt_all[g] = 4'(cnt);

        // Reference: FIFO of payloads with the cycle each was accepted. The
        // oldest entry reaches the output exactly S cycles after acceptance.
        logic [31:0] q_d [$];
        int          q_t [$];
        int          cyc = 0;
        logic        prev_stall = 1'b0;
        logic [31:0] prev_d = '0;
        logic        exp_v;
        logic        exp_r;

        always @(negedge clk) begin
            if (rst) begin
                check($sformatf("i%0d rst valid", g), out_v[g], 0);
                check($sformatf("i%0d rst count", g), cnt_all[g], 0);
                check($sformatf("i%0d rst ready", g), in_rdy[g], 1);
                check($sformatf("i%0d rst data", g), out_d[g], 0);
                q_d.delete();
                q_t.delete();
                prev_stall = 1'b0;
            end else begin
                exp_v = 1'b0;
                if (q_d.size() > 0) exp_v = (cyc - q_t[0]) >= S;
                check($sformatf("i%0d valid c%0d", g, cyc), out_v[g], exp_v);
                if (exp_v) check($sformatf("i%0d data c%0d", g, cyc), out_d[g], q_d[0]);
                check($sformatf("i%0d count c%0d", g, cyc), cnt_all[g], q_d.size());
                if (prev_stall) begin
                    check($sformatf("i%0d stable valid c%0d", g, cyc), out_v[g], 1);
                    check($sformatf("i%0d stable data c%0d", g, cyc), out_d[g], prev_d);
                end
                if (K == 0 || q_d.size() == 0 || q_d.size() == CAP) begin
                    exp_r = (q_d.size() < S) || out_ready_i;
                    if (K != 0) exp_r = (q_d.size() == 0);
                    check($sformatf("i%0d ready c%0d", g, cyc), in_rdy[g], exp_r);
                end
                if (out_v[g] && out_ready_i && q_d.size() > 0) begin
                    void'(q_d.pop_front());
                    void'(q_t.pop_front());
                end
                if (flush_i) begin
                    q_d.delete();
                    q_t.delete();
                end else if (in_valid_i && in_rdy[g]) begin
                    q_d.push_back(in_data_i);
                    q_t.push_back(cyc);
                end
                prev_stall = out_v[g] && !out_ready_i && !flush_i;
                prev_d     = out_d[g];
            end
            cyc++;
        end
    end

    task automatic cyc_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] d, input logic r, input logic f);
        in_valid_i  = v;
        in_data_i   = d;
        out_ready_i = r;
        flush_i     = f;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, $urandom, 1'b1, 1'b0);
            cyc_step();
        end
    endtask

    // Single payload into an empty pipe must appear on instance 0 (3 slices) after 3 cycles.
    task automatic latency_probe(input string tag, input logic [31:0] val);
        for (int i = 0; i < 6; i++) begin
            drive(i == 0, (i == 0) ? val : $urandom, 1'b1, 1'b0);
            @(negedge clk);
            check($sformatf("%s valid c%0d", tag, i), out_v[0], i == 3);
            if (i == 3) check($sformatf("%s data", tag), out_d[0], val);
            cyc_step();
        end
    endtask

    int n_acc;
    int rb;

    initial begin
        rst = 1'b1;
        drive(1'b0, '0, 1'b1, 1'b0);
        cyc_step();
        cyc_step();
        rst = 1'b0;
        drain(2);

        // T1: back-to-back 0x11,0x22,0x33 through 3 slices
        for (int i = 0; i < 7; i++) begin
            if (i < 3) drive(1'b1, 32'h11 * (i + 1), 1'b1, 1'b0);
            else       drive(1'b0, $urandom, 1'b1, 1'b0);
            @(negedge clk);
            check($sformatf("T1 valid c%0d", i), out_v[0], (i >= 3) && (i <= 5));
            if (i >= 3 && i <= 5) check($sformatf("T1 data c%0d", i), out_d[0], 32'h11 * (i - 2));
            cyc_step();
        end

        // T2: 2 slices with skid hold exactly 4 while stalled, then drain 1/cycle
        n_acc = 0;
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, 32'h100 + n_acc, 1'b0, 1'b0);
            @(negedge clk);
            if (!in_rdy[1]) break;
            n_acc++;
            cyc_step();
        end
        check("T2 accepted", n_acc, 4);
        check("T2 count", cnt_all[1], 4);
        cyc_step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, $urandom, 1'b1, 1'b0);
            @(negedge clk);
            check($sformatf("T2 drain valid c%0d", i), out_v[1], i < 4);
            if (i < 4) check($sformatf("T2 drain data c%0d", i), out_d[1], 32'h100 + i);
            cyc_step();
        end
        drain(10);

        // T3: full 3-slice pipe accepts and emits in the same cycle
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h31 + i, 1'b0, 1'b0);
            cyc_step();
        end
        drive(1'b1, 32'h34, 1'b1, 1'b0);
        @(negedge clk);
        check("T3 full ready", in_rdy[0], 1);
        check("T3 full count", cnt_all[0], 3);
        check("T3 head data", out_d[0], 32'h31);
        cyc_step();
        drive(1'b0, $urandom, 1'b0, 1'b0);
        @(negedge clk);
        check("T3 count after", cnt_all[0], 3);
        check("T3 next head", out_d[0], 32'h32);
        cyc_step();
        drain(10);

        // T4: flush with 3 entries and a concurrent 0xAA push
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h41 + i, 1'b0, 1'b0);
            cyc_step();
        end
        drive(1'b1, 32'hAA, 1'b0, 1'b1);
        @(negedge clk);
        check("T4 count before", cnt_all[0], 3);
        cyc_step();
        drive(1'b0, $urandom, 1'b1, 1'b0);
        @(negedge clk);
        check("T4 count after", cnt_all[0], 0);
        check("T4 ready after", in_rdy[0], 1);
        check("T4 valid after", out_v[0], 0);
        cyc_step();
        latency_probe("T4 BB", 32'hBB);
        drain(6);

        // T5: asynchronous reset between edges mid-stream
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, $urandom, 1'b1, 1'b0);
            cyc_step();
        end
        #2 rst = 1'b1;
        #1;
        for (int g = 0; g < 2; g++) begin
            check($sformatf("T5 i%0d valid", g), out_v[g], 0);
            check($sformatf("T5 i%0d count", g), cnt_all[g], 0);
            check($sformatf("T5 i%0d ready", g), in_rdy[g], 1);
        end
        drive(1'b0, $urandom, 1'b1, 1'b0);
        cyc_step();
        cyc_step();
        rst = 1'b0;
        latency_probe("T5 05", 32'h5);
        drain(6);

        // T6: random valid/ready/flush with shifting ready bias
        for (int i = 0; i < 4000; i++) begin
            rb = (i / 500) % 4;
            drive($urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 3) >= rb, $urandom_range(0, 99) == 0);
            cyc_step();
        end
        drain(12);
        @(negedge clk);
        for (int g = 0; g < NI; g++) begin
            check($sformatf("end i%0d count", g), cnt_all[g], 0);
            check($sformatf("end i%0d valid", g), out_v[g], 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
